// File: rtl/uart_fifo_rd_ctrl.sv
// uart_fifo_rd_ctrl
//   Read-side controller of an asynchronous byte FIFO. It synchronises the
//   Gray-coded write pointer into the read clock domain, and keeps the binary
//   and Gray read pointers. It prefetches memory words into a registered
//   output stage with valid/ready handshaking. It also reports how many
//   fetched-but-not-yet-read words remain in memory.
//
// Ports
//   i_rd_ctrl_rclk       read-domain clock (only clock)
//   i_rd_ctrl_rrst_n     asynchronous active-low reset
//   i_rd_ctrl_wptr_gray  Gray write pointer from the write domain (async)
//   i_rd_ctrl_rdata      combinational memory data at o_rd_ctrl_raddr
//   o_rd_ctrl_raddr      memory read address
//   o_rd_ctrl_rptr_gray  registered Gray read pointer for the write domain
//   o_rd_ctrl_empty      no unfetched word left in memory
//   o_rd_ctrl_data       registered output byte
//   o_rd_ctrl_valid      o_rd_ctrl_data holds a word
//   i_rd_ctrl_ready      consumer accepts the held word
//   o_rd_ctrl_count      unfetched words in memory (0..FIFO_DEPTH)
module uart_fifo_rd_ctrl #(
   parameter int FIFO_DEPTH = 8,
   parameter int PTR_WIDTH  = $clog2(FIFO_DEPTH) + 1
) (
   input  logic                 i_rd_ctrl_rclk,
   input  logic                 i_rd_ctrl_rrst_n,
   input  logic [PTR_WIDTH-1:0] i_rd_ctrl_wptr_gray,
   input  logic [7:0]           i_rd_ctrl_rdata,
   output logic [PTR_WIDTH-2:0] o_rd_ctrl_raddr,
   output logic [PTR_WIDTH-1:0] o_rd_ctrl_rptr_gray,
   output logic                 o_rd_ctrl_empty,
   output logic [7:0]           o_rd_ctrl_data,
   output logic                 o_rd_ctrl_valid,
   input  logic                 i_rd_ctrl_ready,
   output logic [PTR_WIDTH-1:0] o_rd_ctrl_count
);

   // The pointer needs exactly one wrap bit above the memory address.
   if (PTR_WIDTH != $clog2(FIFO_DEPTH) + 1) begin : g_bad_ptr_width
      $error("uart_fifo_rd_ctrl: PTR_WIDTH must equal $clog2(FIFO_DEPTH)+1");
   end

   // Bit i of the binary value is the XOR of all Gray bits at or above i.
   function automatic logic [PTR_WIDTH-1:0] gray2bin(input logic [PTR_WIDTH-1:0] g);
      logic [PTR_WIDTH-1:0] b;
      b = '0;
      for (int unsigned i = 0; i < PTR_WIDTH; i++) begin
         b[i] = ^(g >> i);
      end
      return b;
   endfunction

   logic [PTR_WIDTH-1:0] wq1_q, wq2_q;
   logic [PTR_WIDTH-1:0] rbin_q, rbin_d;
   logic [PTR_WIDTH-1:0] rgray_q, rgray_d;
   logic [7:0]           data_q, data_d;
   logic                 valid_q, valid_d;
   logic [PTR_WIDTH-1:0] count_q, count_d;
   logic                 empty;
   logic                 fetch;

   assign empty = (rgray_q == wq2_q);
   // Load the output stage when it is free or being drained this cycle.
   assign fetch = !empty && (!valid_q || i_rd_ctrl_ready);

   always_comb begin
      rbin_d  = rbin_q;
      data_d  = data_q;
      valid_d = valid_q;
      if (fetch) begin
         data_d  = i_rd_ctrl_rdata;
         valid_d = 1'b1;
         rbin_d  = rbin_q + PTR_WIDTH'(1);
      end else if (valid_q && i_rd_ctrl_ready) begin
         valid_d = 1'b0;
      end
      rgray_d = rbin_d ^ (rbin_d >> 1);
      // wq1_q is the value wq2_q takes on this edge, so count tracks the
      // post-edge pointers without an extra cycle of lag.
      count_d = gray2bin(wq1_q) - rbin_d;
   end

   always_ff @(posedge i_rd_ctrl_rclk or negedge i_rd_ctrl_rrst_n) begin
      if (!i_rd_ctrl_rrst_n) begin
         wq1_q   <= '0;
         wq2_q   <= '0;
         rbin_q  <= '0;
         rgray_q <= '0;
         data_q  <= '0;
         valid_q <= 1'b0;
         count_q <= '0;
      end else begin
         wq1_q   <= i_rd_ctrl_wptr_gray;
         wq2_q   <= wq1_q;
         rbin_q  <= rbin_d;
         rgray_q <= rgray_d;
         data_q  <= data_d;
         valid_q <= valid_d;
         count_q <= count_d;
      end
   end

   assign o_rd_ctrl_raddr     = rbin_q[PTR_WIDTH-2:0];
   assign o_rd_ctrl_rptr_gray = rgray_q;
   assign o_rd_ctrl_empty     = empty;
   assign o_rd_ctrl_data      = data_q;
   assign o_rd_ctrl_valid     = valid_q;
   assign o_rd_ctrl_count     = count_q;

endmodule

// File: tb/tb_uart_fifo_rd_ctrl.sv
// tb_uart_fifo_rd_ctrl
//   Bench for uart_fifo_rd_ctrl at FIFO_DEPTH=8 (PTR_WIDTH=4). A small array
//   models the FIFO memory, a queue holds the bytes written in order, and
//   every accepted word is popped from it and compared.
module tb_uart_fifo_rd_ctrl;

   logic       clk = 1'b0;
   logic       clk_en = 1'b0;
   logic       rst_n = 1'b1;
   logic [3:0] wptr_gray = '0;
   logic [7:0] rdata;
   logic [2:0] raddr;
   logic [3:0] rptr_gray;
   logic       empty;
   logic [7:0] data;
   logic       valid;
   logic       ready = 1'b0;
   logic [3:0] count;

   logic [7:0] mem [8];
   logic [7:0] sb_q [$];
   int         n_chk = 0;
   int         n_fail = 0;
   int         wbin = 0;
   int         acc = 0;

   uart_fifo_rd_ctrl #(.FIFO_DEPTH(8), .PTR_WIDTH(4)) dut (
      .i_rd_ctrl_rclk      (clk),
      .i_rd_ctrl_rrst_n    (rst_n),
      .i_rd_ctrl_wptr_gray (wptr_gray),
      .i_rd_ctrl_rdata     (rdata),
      .o_rd_ctrl_raddr     (raddr),
      .o_rd_ctrl_rptr_gray (rptr_gray),
      .o_rd_ctrl_empty     (empty),
      .o_rd_ctrl_data      (data),
      .o_rd_ctrl_valid     (valid),
      .i_rd_ctrl_ready     (ready),
      .o_rd_ctrl_count     (count)
   );

   assign rdata = mem[raddr];

   initial begin
      forever begin
         #5;
         if (clk_en) clk = ~clk;
      end
   end

   initial begin
      #1_000_000;
      $display("FAIL watchdog: simulation did not finish, got running expected finished");
      $fatal(1, "watchdog");
   end

   function automatic logic [3:0] to_gray(input logic [3:0] b);
      return b ^ (b >> 1);
   endfunction

   task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
      n_chk++;
      if (act !== exp) begin
         n_fail++;
         $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", name, act, exp, $time);
      end
   endtask

   task automatic timeout(input string name);
      n_chk++;
      n_fail++;
      $display("FAIL %s: got timeout expected event at %0t", name, $time);
   endtask

   // Scoreboard: a word is accepted at the rising edge that follows a
   // falling edge seen with valid && ready.
   always @(negedge clk) begin
      if (rst_n && valid && ready) begin
         if (sb_q.size() == 0) begin
            n_chk++;
            n_fail++;
            $display("FAIL sb_unexpected: got 0x%0h expected no word at %0t", data, $time);
         end else begin
            check("sb_data", data, sb_q.pop_front());
         end
         acc++;
      end
   end

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   task automatic write_word(input logic [7:0] d);
      logic [3:0] w4;
      mem[wbin % 8] = d;
      sb_q.push_back(d);
      wbin++;
      w4 = wbin[3:0];
      wptr_gray = to_gray(w4);
   endtask

   task automatic do_reset();
      ready = 1'b0;
      rst_n = 1'b0;
      #1;
      sb_q.delete();
      wbin = 0;
      acc = 0;
      wptr_gray = '0;
      @(posedge clk);
      #1;
      rst_n = 1'b1;
   endtask

   task automatic check_reset_values(input string tag);
      check({tag, "_valid"}, valid, 1'b0);
      check({tag, "_empty"}, empty, 1'b1);
      check({tag, "_raddr"}, raddr, 3'd0);
      check({tag, "_rptr_gray"}, rptr_gray, 4'd0);
      check({tag, "_data"}, data, 8'h00);
      check({tag, "_count"}, count, 4'd0);
   endtask

   typedef struct {
      bit         rst;
      bit         wr;
      logic [7:0] wdat;
      bit         rdy;
      bit         e_valid;
      bit         e_empty;
      logic [7:0] e_data;
      logic [2:0] e_raddr;
      logic [3:0] e_rgray;
      logic [3:0] e_count;
   } vec_t;

   vec_t vecs [12];

   initial begin
      logic [2:0] prev_raddr;
      logic [3:0] prev_g;
      bit         saw_addr_wrap;
      bit         saw_gray_wrap;
      bit         done;
      int         written;

      // rst wr wdat rdy | valid empty data raddr rgray count
      vecs[0]  = '{1, 1, 8'hA5, 1, 0, 1, 8'h00, 3'd0, 4'b0000, 4'd0};
      vecs[1]  = '{0, 0, 8'h00, 1, 0, 0, 8'h00, 3'd0, 4'b0000, 4'd1};
      vecs[2]  = '{0, 0, 8'h00, 1, 1, 1, 8'hA5, 3'd1, 4'b0001, 4'd0};
      vecs[3]  = '{0, 0, 8'h00, 1, 0, 1, 8'hA5, 3'd1, 4'b0001, 4'd0};
      vecs[4]  = '{1, 1, 8'h11, 0, 0, 1, 8'h00, 3'd0, 4'b0000, 4'd0};
      vecs[5]  = '{0, 1, 8'h22, 0, 0, 0, 8'h00, 3'd0, 4'b0000, 4'd1};
      vecs[6]  = '{0, 1, 8'h33, 0, 1, 0, 8'h11, 3'd1, 4'b0001, 4'd1};
      vecs[7]  = '{0, 0, 8'h00, 0, 1, 0, 8'h11, 3'd1, 4'b0001, 4'd2};
      vecs[8]  = '{0, 0, 8'h00, 0, 1, 0, 8'h11, 3'd1, 4'b0001, 4'd2};
      vecs[9]  = '{0, 0, 8'h00, 1, 1, 0, 8'h22, 3'd2, 4'b0011, 4'd1};
      vecs[10] = '{0, 0, 8'h00, 1, 1, 1, 8'h33, 3'd3, 4'b0010, 4'd0};
      vecs[11] = '{0, 0, 8'h00, 1, 0, 1, 8'h33, 3'd3, 4'b0010, 4'd0};

      for (int i = 0; i < 8; i++) mem[i] = '0;

      // Reset with the clock stopped.
      #2 rst_n = 1'b0;
      #2 check_reset_values("rst_noclk");
      clk_en = 1'b1;

      // Single word and back-pressure sequences.
      for (int i = 0; i < 12; i++) begin
         if (vecs[i].rst) do_reset();
         ready = vecs[i].rdy;
         if (vecs[i].wr) write_word(vecs[i].wdat);
         tick();
         check($sformatf("vec%0d_valid", i), valid, vecs[i].e_valid);
         check($sformatf("vec%0d_empty", i), empty, vecs[i].e_empty);
         check($sformatf("vec%0d_data", i), data, vecs[i].e_data);
         check($sformatf("vec%0d_raddr", i), raddr, vecs[i].e_raddr);
         check($sformatf("vec%0d_rptr_gray", i), rptr_gray, vecs[i].e_rgray);
         check($sformatf("vec%0d_count", i), count, vecs[i].e_count);
      end

      // Stream 20 words through the pointer wrap.
      do_reset();
      ready = 1'b1;
      written = 0;
      prev_raddr = raddr;
      prev_g = rptr_gray;
      saw_addr_wrap = 1'b0;
      saw_gray_wrap = 1'b0;
      for (int cyc = 0; cyc < 300 && acc < 20; cyc++) begin
         if (written < 20 && (wbin - acc) < 8) begin
            write_word(8'h40 + 8'(written));
            written++;
         end
         tick();
         check("wrap_gray_step", ($countones(prev_g ^ rptr_gray) <= 1), 1);
         if (prev_raddr == 3'd7 && raddr == 3'd0) saw_addr_wrap = 1'b1;
         if (prev_g == 4'b1000 && rptr_gray == 4'b0000) saw_gray_wrap = 1'b1;
         prev_raddr = raddr;
         prev_g = rptr_gray;
      end
      if (acc < 20) timeout("wrap_stream");
      check("wrap_accepted", acc, 20);
      check("wrap_raddr_7to0", saw_addr_wrap, 1'b1);
      check("wrap_gray_1000to0000", saw_gray_wrap, 1'b1);
      tick();
      check("wrap_sb_empty", sb_q.size(), 0);
      check("wrap_valid_end", valid, 1'b0);

      // Full memory drained at one word per cycle.
      do_reset();
      for (int i = 0; i < 8; i++) write_word(8'h80 + 8'(i));
      ready = 1'b1;
      done = 1'b0;
      for (int cyc = 0; cyc < 10 && !done; cyc++) begin
         tick();
         if (count == 4'd8) done = 1'b1;
      end
      if (!done) timeout("fe_count8");
      check("fe_valid_at_full", valid, 1'b0);
      for (int k = 1; k <= 8; k++) begin
         tick();
         check($sformatf("fe_valid_%0d", k), valid, 1'b1);
         check($sformatf("fe_count_%0d", k), count, 4'(8 - k));
      end
      tick();
      check("fe_valid_drop", valid, 1'b0);
      check("fe_count_end", count, 4'd0);
      check("fe_empty_end", empty, 1'b1);
      check("fe_sb_empty", sb_q.size(), 0);

      // Advance rbin to 15, then hold one word with rbin wrapped to 0.
      for (int i = 0; i < 7; i++) write_word(8'hC0 + 8'(i));
      done = 1'b0;
      for (int cyc = 0; cyc < 30 && !done; cyc++) begin
         tick();
         if (sb_q.size() == 0 && !valid) done = 1'b1;
      end
      if (!done) timeout("rm_drain");
      ready = 1'b0;
      for (int i = 0; i < 4; i++) write_word(8'hE0 + 8'(i));
      done = 1'b0;
      for (int cyc = 0; cyc < 10 && !done; cyc++) begin
         tick();
         if (valid && count == 4'd3) done = 1'b1;
      end
      if (!done) timeout("rm_fill");
      tick();
      tick();
      check("rm_pre_valid", valid, 1'b1);
      check("rm_pre_count", count, 4'd3);
      check("rm_pre_data", data, 8'hE0);
      check("rm_pre_raddr", raddr, 3'd0);
      check("rm_pre_rptr_gray", rptr_gray, 4'b0000);

      // Asynchronous reset pulse mid-cycle.
      #2 rst_n = 1'b0;
      #1 check_reset_values("rm_rst");
      sb_q.delete();
      @(posedge clk);
      #1 rst_n = 1'b1;
      tick();
      check("rm_edge1_count", count, 4'd0);
      check("rm_edge1_empty", empty, 1'b1);
      tick();
      check("rm_edge2_count", count, 4'd3);
      check("rm_edge2_empty", empty, 1'b0);
      check("rm_edge2_valid", valid, 1'b0);
      check("rm_edge2_raddr", raddr, 3'd0);

      $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
      $finish;
   end

endmodule
